// File: rtl/display_out.sv
// Serial driver for the 7-segment display chain: decodes four BCD digits,
// appends 32 raw segment bits and shifts the 64-bit frame out MSB-first.
module display_out #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] bcd_in,
    input  logic [31:0] segment_data,
    output logic        data_out,
    output logic        sending_data
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q;
    logic [63:0]      frame_q;
    logic [63:0]      frame_d;
    logic [5:0]       bit_cnt_q;
    logic [DIV_W-1:0] div_q;
    logic [GAP_W-1:0] gap_q;
    logic             data_out_q;
    logic             sending_q;

    // Active-low {dp,g,f,e,d,c,b,a}; non-decimal codes show a dash.
    function automatic logic [7:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 8'hC0;
            4'd1:    dec7 = 8'hF9;
            4'd2:    dec7 = 8'hA4;
            4'd3:    dec7 = 8'hB0;
            4'd4:    dec7 = 8'h99;
            4'd5:    dec7 = 8'h92;
            4'd6:    dec7 = 8'h82;
            4'd7:    dec7 = 8'hF8;
            4'd8:    dec7 = 8'h80;
            4'd9:    dec7 = 8'h90;
            default: dec7 = 8'hBF;
        endcase
    endfunction

    assign frame_d = {dec7(bcd_in[15:12]), dec7(bcd_in[11:8]),
                      dec7(bcd_in[7:4]),   dec7(bcd_in[3:0]), segment_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            div_q      <= '0;
            gap_q      <= '0;
            data_out_q <= 1'b0;
            sending_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        // First bit goes out on the same edge that latches the frame.
                        frame_q    <= frame_d;
                        data_out_q <= frame_d[63];
                        sending_q  <= 1'b1;
                        bit_cnt_q  <= 6'd63;
                        div_q      <= '0;
                        state_q    <= SHIFT;
                    end else begin
                        data_out_q <= 1'b0;
                        sending_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (div_q == DIV_MAX) begin
                        div_q <= '0;
                        if (bit_cnt_q == 6'd0) begin
                            data_out_q <= 1'b0;
                            sending_q  <= 1'b0;
                            gap_q      <= '0;
                            state_q    <= (GAP_CYCLES > 0) ? GAP : IDLE;
                        end else begin
                            bit_cnt_q  <= bit_cnt_q - 6'd1;
                            data_out_q <= frame_q[bit_cnt_q - 6'd1];
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                GAP: begin
                    if (gap_q == GAP_MAX) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out     = data_out_q;
    assign sending_data = sending_q;

endmodule

// File: tb/tb_display_out.sv
// Directed + randomized bench for display_out; expected frames come from a
// digit lookup table and the frame layout, bits are checked cycle by cycle.
module tb_display_out;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 8;
    localparam logic [7:0] LUT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [31:0] segment_data = '0;
    logic        data_out;
    logic        sending_data;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    display_out #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .reset(reset), .enable(enable), .bcd_in(bcd_in),
        .segment_data(segment_data), .data_out(data_out), .sending_data(sending_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] frame_of(input logic [15:0] b, input logic [31:0] s);
        logic [63:0] f;
        f[31:0] = s;
        for (int d = 0; d < 4; d++) f[32 + 8*d +: 8] = LUT[b[4*d +: 4]];
        return f;
    endfunction

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Checks the top nbits bits of a frame; entered at the negedge where bit 63 shows.
    task automatic check_bits(input logic [63:0] exp, input int nbits, input string tag);
        for (int b = 63; b > 63 - nbits; b--) begin
            for (int c = 0; c < CLK_DIV; c++) begin
                chk(64'(sending_data), 64'd1, $sformatf("%s busy b%0d", tag, b));
                chk(64'(data_out), 64'(exp[b]), $sformatf("%s data b%0d", tag, b));
                @(negedge clk);
            end
        end
    endtask

    task automatic check_gap(input string tag);
        for (int i = 0; i < GAP_CYCLES; i++) begin
            chk(64'(sending_data), 64'd0, $sformatf("%s gap send %0d", tag, i));
            chk(64'(data_out), 64'd0, $sformatf("%s gap data %0d", tag, i));
            @(negedge clk);
        end
    endtask

    task automatic wait_start(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (sending_data !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(64'(sending_data), 64'd1, {tag, " start"});
    endtask

    logic [63:0] exp_f;
    logic [15:0] nb;
    logic [31:0] ns;
    int          t0;

    initial begin
        // Reset and first frame
        enable = 1'b1;
        bcd_in = 16'h2571;
        segment_data = 32'hC0F83F0F;
        @(negedge clk);
        chk(64'(sending_data), 64'd0, "reset send");
        chk(64'(data_out), 64'd0, "reset data");
        reset = 1'b0;
        t0 = cyc;
        @(negedge clk);
        chk(64'(sending_data), 64'd1, "first edge start");
        exp_f = frame_of(bcd_in, segment_data);
        check_bits(exp_f, 64, "f1");
        check_gap("f1");

        // Continuous refresh; inputs swapped mid-frame apply only to the next one
        wait_start(GAP_CYCLES + 4, "f2");
        fork
            check_bits(exp_f, 64, "f2");
            begin
                repeat (120) @(negedge clk);
                bcd_in = 16'hFA09;
                segment_data = $urandom;
            end
        join
        check_gap("f2");
        wait_start(GAP_CYCLES + 4, "f3");
        chk(64'(cyc - t0 < 900), 64'd1, "third frame within 900");
        exp_f = frame_of(bcd_in, segment_data);
        chk(exp_f[63:32], 64'hBFBFC090, "f3 decode ref");
        fork
            check_bits(exp_f, 64, "f3");
            begin
                repeat (128) @(negedge clk);
                bcd_in = 16'h8888;
            end
        join
        check_gap("f3");
        wait_start(GAP_CYCLES + 4, "f4");
        exp_f = frame_of(bcd_in, segment_data);
        check_bits(exp_f, 64, "f4");
        check_gap("f4");

        // Randomized frames, inputs changed while each is in flight
        for (int r = 0; r < 3; r++) begin
            nb = 16'($urandom);
            ns = $urandom;
            wait_start(GAP_CYCLES + 4, $sformatf("r%0d", r));
            fork
                check_bits(exp_f, 64, $sformatf("r%0d", r));
                begin
                    repeat ($urandom_range(1, 250)) @(negedge clk);
                    bcd_in = nb;
                    segment_data = ns;
                end
            join
            check_gap($sformatf("r%0d", r));
            exp_f = frame_of(nb, ns);
        end

        // Reset during bit 20, then a fresh frame
        wait_start(GAP_CYCLES + 4, "pre-rst");
        check_bits(exp_f, 43, "pre-rst");
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk(64'(sending_data), 64'd0, "async rst send");
        chk(64'(data_out), 64'd0, "async rst data");
        bcd_in = 16'($urandom);
        segment_data = $urandom;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk(64'(sending_data), 64'd1, "post-rst start");
        exp_f = frame_of(bcd_in, segment_data);
        check_bits(exp_f, 64, "post-rst");

        // Idle with enable low, then a single one-cycle pulse
        enable = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            chk(64'(sending_data), 64'd0, "idle send");
            chk(64'(data_out), 64'd0, "idle data");
            @(negedge clk);
        end
        bcd_in = 16'($urandom);
        segment_data = $urandom;
        exp_f = frame_of(bcd_in, segment_data);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_start(4, "pulse");
        check_bits(exp_f, 64, "pulse");
        for (int i = 0; i < 300; i++) begin
            chk(64'(sending_data), 64'd0, "after pulse send");
            chk(64'(data_out), 64'd0, "after pulse data");
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
